jk_from_t_reg: RTL and testbench



---
 rtl/jk_from_t_reg_pkg.sv | 25 ++
 rtl/jk_from_t_reg_t_ff_cell.sv | 15 +
 rtl/jk_from_t_reg.sv | 81 ++++++++
 tb/tb_jk_from_t_reg.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_from_t_reg_pkg.sv
// Shared types and mode encodings for the JK-from-T register bank.
// Imported by the top level; the T cell itself needs nothing from it.
package jk_from_t_reg_pkg;

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DN   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 16;

  // JK-to-T excitation for one bit.
  // Toggle when J sets a 0 or K clears a 1.
  function automatic logic jk_to_t(
    input logic j,
    input logic k,
    input logic q
  );
    return (j & ~q) | (k & q);
  endfunction

endpackage

// File: rtl/jk_from_t_reg_t_ff_cell.sv
// Single T flip-flop with synchronous active-high reset.
// Ports: clk, rst, T (toggle request), Q (state).
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic T,
  output logic Q
);

  always_ff @(posedge clk) begin
    if (rst) Q <= 1'b0;
    else     Q <= Q ^ T;
  end

endmodule

// File: rtl/jk_from_t_reg.sv
// WIDTH-bit JK register / up-down counter built on T flip-flops.
// Ports: clk, rst, en, load, mode, J, K, d -> Q, Qn, tc.
module jk_from_t_reg
  import jk_from_t_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             tc
);

  mode_t            m;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] t_jk;
  logic [WIDTH-1:0] up_c;
  logic [WIDTH-1:0] dn_c;

  assign m = mode_t'(mode);

  // Ripple toggle chains: bit i flips when all
  // lower bits are 1 (up) or all are 0 (down).
  always_comb begin
    up_c    = '0;
    dn_c    = '0;
    up_c[0] = 1'b1;
    dn_c[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_c[i] = up_c[i-1] & Q[i-1];
      dn_c[i] = dn_c[i-1] & ~Q[i-1];
    end
  end

  always_comb begin
    t_jk = '0;
    for (int i = 0; i < WIDTH; i++)
      t_jk[i] = jk_to_t(J[i], K[i], Q[i]);
  end

  // rst is handled inside each cell, so here
  // only en > load > mode matters.
  always_comb begin
    t = '0;
    if (!en) begin
      t = '0;
    end else if (load) begin
      t = Q ^ d;
    end else begin
      unique case (m)
        MODE_JK:   t = t_jk;
        MODE_UP:   t = up_c;
        MODE_DN:   t = dn_c;
        MODE_HOLD: t = '0;
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    t_ff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .T   (t[g]),
      .Q   (Q[g])
    );
  end

  assign Qn = ~Q;

  assign tc = en & ~load &
              (((m == MODE_UP) & (&Q)) |
               ((m == MODE_DN) & ~(|Q)));

endmodule

// File: tb/tb_jk_from_t_reg.sv
// Directed and model-checked bench for jk_from_t_reg.
// Drives a WIDTH=4 and a WIDTH=1 instance from shared controls.
module tb_jk_from_t_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [1:0] mode = 2'b11;
  logic [3:0] J = '0, K = '0, d = '0;
  logic [3:0] Q, Qn;
  logic       tc;
  logic [0:0] J1 = '0, K1 = '0, d1 = '0;
  logic [0:0] Q1, Qn1;
  logic       tc1;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  jk_from_t_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .mode(mode), .J(J), .K(K), .d(d),
    .Q(Q), .Qn(Qn), .tc(tc)
  );

  jk_from_t_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .mode(mode), .J(J1), .K(K1), .d(d1),
    .Q(Q1), .Qn(Qn1), .tc(tc1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural next state: JK characteristic
  // equation and arithmetic +/-1.
  function automatic logic [3:0] ref_next(
    input logic [3:0] q, input int w,
    input logic r, input logic e, input logic l,
    input logic [1:0] md,
    input logic [3:0] j, input logic [3:0] k,
    input logic [3:0] dd
  );
    logic [3:0] mask;
    mask = 4'((1 << w) - 1);
    if (r) return '0;
    if (!e) return q;
    if (l) return dd & mask;
    case (md)
      2'b00: return ((j & ~q) | (~k & q)) & mask;
      2'b01: return (q + 4'd1) & mask;
      2'b10: return (q - 4'd1) & mask;
      default: return q;
    endcase
  endfunction

  function automatic logic ref_tc(
    input logic [3:0] q, input int w,
    input logic e, input logic l,
    input logic [1:0] md
  );
    logic [3:0] mask;
    mask = 4'((1 << w) - 1);
    return e && !l &&
      ((md == 2'b01 && q == mask) ||
       (md == 2'b10 && q == 4'd0));
  endfunction

  task automatic test_reset();
    rst = 1; en = 1; load = 0;
    mode = 2'b01; J = 4'hF; K = 4'hF;
    tick(); tick();
    vecs++;
    if (Q !== 4'h0) begin
      miss++;
      $display("FAIL reset_q: got %h want 0", Q);
    end
    vecs++;
    if (Qn !== 4'hF) begin
      miss++;
      $display("FAIL reset_qn: got %h want f", Qn);
    end
    vecs++;
    if (tc !== 1'b0) begin
      miss++;
      $display("FAIL reset_tc: got %b want 0", tc);
    end
    rst = 0;
    tick();
    vecs++;
    if (Q !== 4'h1) begin
      miss++;
      $display("FAIL reset_resume: got %h want 1", Q);
    end
  endtask

  task automatic test_jk();
    logic [3:0] jv[4] = '{4'b1010, 4'b1111, 4'b0000, 4'b0000};
    logic [3:0] kv[4] = '{4'b0101, 4'b1111, 4'b0100, 4'b0000};
    logic [3:0] qv[4] = '{4'b1010, 4'b0101, 4'b0001, 4'b0001};
    rst = 1; tick(); rst = 0;
    en = 1; load = 0; mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      J = jv[i]; K = kv[i];
      #1;
      vecs++;
      if (tc !== 1'b0) begin
        miss++;
        $display("FAIL jk_tc[%0d]: got %b want 0", i, tc);
      end
      tick();
      vecs++;
      if (Q !== qv[i]) begin
        miss++;
        $display("FAIL jk_q[%0d]: got %b want %b", i, Q, qv[i]);
      end
    end
    J = 0; K = 0;
  endtask

  task automatic test_count_up();
    logic [3:0] eq;
    rst = 1; tick(); rst = 0;
    en = 1; load = 0; mode = 2'b01;
    for (int i = 0; i < 17; i++) begin
      eq = 4'(i % 16);
      #1;
      vecs++;
      if (Q !== eq) begin
        miss++;
        $display("FAIL up_q[%0d]: got %h want %h", i, Q, eq);
      end
      vecs++;
      if (tc !== (eq == 4'hF)) begin
        miss++;
        $display("FAIL up_tc[%0d]: got %b want %b",
                 i, tc, eq == 4'hF);
      end
      tick();
    end
    vecs++;
    if (Q !== 4'h1) begin
      miss++;
      $display("FAIL up_final: got %h want 1", Q);
    end
    rst = 1; tick(); rst = 0;
    repeat (7) tick();
    en = 0;
    #1;
    vecs++;
    if (tc !== 1'b0) begin
      miss++;
      $display("FAIL up_pause_tc: got %b want 0", tc);
    end
    tick(); tick();
    vecs++;
    if (Q !== 4'h7) begin
      miss++;
      $display("FAIL up_pause_q: got %h want 7", Q);
    end
    en = 1;
  endtask

  task automatic test_count_down();
    logic [3:0] qv[4] = '{4'h2, 4'h1, 4'h0, 4'hF};
    en = 1; mode = 2'b10; load = 1; d = 4'h2;
    tick();
    load = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vecs++;
      if (Q !== qv[i]) begin
        miss++;
        $display("FAIL dn_q[%0d]: got %h want %h", i, Q, qv[i]);
      end
      vecs++;
      if (tc !== (qv[i] == 4'h0)) begin
        miss++;
        $display("FAIL dn_tc[%0d]: got %b want %b",
                 i, tc, qv[i] == 4'h0);
      end
      tick();
    end
  endtask

  task automatic test_priority();
    en = 1; mode = 2'b11; load = 1; d = 4'h9;
    tick();
    vecs++;
    if (Q !== 4'h9) begin
      miss++;
      $display("FAIL pri_load_hold: got %h want 9", Q);
    end
    load = 0; d = 4'h3;
    tick();
    vecs++;
    if (Q !== 4'h9) begin
      miss++;
      $display("FAIL pri_mode_hold: got %h want 9", Q);
    end
    en = 0; load = 1;
    tick();
    vecs++;
    if (Q !== 4'h9) begin
      miss++;
      $display("FAIL pri_en_load: got %h want 9", Q);
    end
    en = 1; rst = 1; load = 1; d = 4'h9;
    tick();
    vecs++;
    if (Q !== 4'h0) begin
      miss++;
      $display("FAIL pri_rst_load: got %h want 0", Q);
    end
    rst = 0; load = 0;
  endtask

  task automatic test_random();
    logic [3:0] m4, m1;
    rst = 1; tick(); rst = 0;
    m4 = '0; m1 = '0;
    for (int i = 0; i < 1000; i++) begin
      rst  = ($urandom_range(63) == 0);
      en   = ($urandom_range(7) != 0);
      load = ($urandom_range(7) == 0);
      mode = 2'($urandom_range(3));
      J = 4'($urandom); K = 4'($urandom);
      d = 4'($urandom);
      J1 = 1'($urandom); K1 = 1'($urandom);
      d1 = 1'($urandom);
      #1;
      vecs++;
      if (tc !== ref_tc(m4, 4, en, load, mode)) begin
        miss++;
        $display("FAIL rnd_tc4[%0d]: got %b want %b",
                 i, tc, ref_tc(m4, 4, en, load, mode));
      end
      vecs++;
      if (tc1 !== ref_tc(m1, 1, en, load, mode)) begin
        miss++;
        $display("FAIL rnd_tc1[%0d]: got %b want %b",
                 i, tc1, ref_tc(m1, 1, en, load, mode));
      end
      m4 = ref_next(m4, 4, rst, en, load, mode, J, K, d);
      m1 = ref_next(m1, 1, rst, en, load, mode,
                    {3'b0, J1}, {3'b0, K1}, {3'b0, d1});
      tick();
      vecs++;
      if (Q !== m4 || Qn !== ~m4) begin
        miss++;
        $display("FAIL rnd_q4[%0d]: got %h/%h want %h",
                 i, Q, Qn, m4);
      end
      vecs++;
      if (Q1 !== m1[0] || Qn1 !== ~m1[0]) begin
        miss++;
        $display("FAIL rnd_q1[%0d]: got %b/%b want %b",
                 i, Q1, Qn1, m1[0]);
      end
    end
    rst = 0;
  endtask

  initial begin
    #2;
    test_reset();
    test_jk();
    test_count_up();
    test_count_down();
    test_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
